// File: rtl/fast_adc_pkg.sv
// Shared widths, lane state encoding and the offset-binary conversion for the
// fast ADC receive path.
package fast_adc_pkg;

  localparam int ADC_W     = 16;
  localparam int ERR_CNT_W = 8;
  localparam int ALT_CNT_W = 4;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  // Offset-binary to two's complement is just an MSB flip.
  function automatic logic [ADC_W-1:0] to_twos(input logic [ADC_W-1:0] word,
                                               input bit               offset_bin);
    return offset_bin ? {~word[ADC_W-1], word[ADC_W-2:0]} : word;
  endfunction

endpackage

// File: rtl/fast_adc_lane.sv
// One interleaved A/B ADC lane: input register, alternation lock FSM,
// A-word latch, paired output register and framing-error counter.
module fast_adc_lane
  import fast_adc_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADC_W-1:0]     adc_data,
  input  logic                 adc_sel,
  output logic [2*ADC_W-1:0]   pair,
  output logic                 pair_valid,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ALT_CNT_W-1:0] LOCK_THR = ALT_CNT_W'(LOCK_CNT);
  localparam logic [ALT_CNT_W-1:0] ALT_MAX  = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  logic [ADC_W-1:0]     data_r;
  logic                 sel_r;
  logic                 prev_sel;
  lane_state_e          state, next_state;
  logic [ALT_CNT_W-1:0] alt_cnt, alt_cnt_nxt;
  logic [ADC_W-1:0]     a_latch, a_latch_nxt;
  logic [2*ADC_W-1:0]   pair_nxt;
  logic                 valid_nxt;
  logic                 err_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;
  logic                 repeat_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= '0;
      sel_r    <= 1'b0;
      prev_sel <= 1'b0;
    end else begin
      data_r   <= to_twos(adc_data, OFFSET_BIN);
      sel_r    <= adc_sel;
      prev_sel <= sel_r;
    end
  end

  assign repeat_sel = (sel_r == prev_sel);

  // A pair is committed only on a clean A->B step, so A and B always move together.
  always_comb begin
    next_state  = state;
    alt_cnt_nxt = alt_cnt;
    a_latch_nxt = a_latch;
    pair_nxt    = pair;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    case (state)
      HUNT: begin
        if (repeat_sel) begin
          alt_cnt_nxt = '0;
        end else if (alt_cnt != ALT_MAX) begin
          alt_cnt_nxt = alt_cnt + 1'b1;
        end
        if (!repeat_sel && sel_r && (alt_cnt_nxt >= LOCK_THR)) begin
          next_state  = LOCKED;
          alt_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (repeat_sel) begin
          err_nxt     = 1'b1;
          next_state  = HUNT;
          alt_cnt_nxt = '0;
          if (err_cnt != ERR_MAX) begin
            err_cnt_nxt = err_cnt + 1'b1;
          end
        end else if (!sel_r) begin
          a_latch_nxt = data_r;
        end else begin
          pair_nxt  = {data_r, a_latch};
          valid_nxt = 1'b1;
        end
      end
      default: begin
        next_state  = HUNT;
        alt_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      alt_cnt    <= '0;
      a_latch    <= '0;
      pair       <= '0;
      pair_valid <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= next_state;
      alt_cnt    <= alt_cnt_nxt;
      a_latch    <= a_latch_nxt;
      pair       <= pair_nxt;
      pair_valid <= valid_nxt;
      err        <= err_nxt;
      err_cnt    <= err_cnt_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/fast_adc_rx.sv
// Receive side for N_ADC interleaved dual-channel fast ADC lanes; each lane
// locks and pairs independently, the top only packs the per-lane buses.
module fast_adc_rx
  import fast_adc_pkg::*;
#(
  parameter int N_ADC      = 7,
  parameter int LOCK_CNT   = 4,
  parameter bit OFFSET_BIN = 1'b1
) (
  input  logic                       clk_in,
  input  logic                       rstn_in,
  input  logic [N_ADC*ADC_W-1:0]     fADC_in,
  input  logic [N_ADC-1:0]           fADC_sel_in,
  output logic [N_ADC*2*ADC_W-1:0]   s_out,
  output logic [N_ADC-1:0]           s_valid_out,
  output logic [N_ADC-1:0]           locked_out,
  output logic [N_ADC-1:0]           err_out,
  output logic [N_ADC*ERR_CNT_W-1:0] err_cnt_out
);

  for (genvar k = 0; k < N_ADC; k++) begin : g_lane
    fast_adc_lane #(
      .LOCK_CNT   (LOCK_CNT),
      .OFFSET_BIN (OFFSET_BIN)
    ) u_lane (
      .clk        (clk_in),
      .rst_n      (rstn_in),
      .adc_data   (fADC_in[k*ADC_W +: ADC_W]),
      .adc_sel    (fADC_sel_in[k]),
      .pair       (s_out[k*2*ADC_W +: 2*ADC_W]),
      .pair_valid (s_valid_out[k]),
      .locked     (locked_out[k]),
      .err        (err_out[k]),
      .err_cnt    (err_cnt_out[k*ERR_CNT_W +: ERR_CNT_W])
    );
  end

endmodule

// File: tb/tb_fast_adc_rx.sv
// Randomized bench for fast_adc_rx against a word-by-word behavioural model of
// lock, pairing and framing-error rules.
module tb_fast_adc_rx;

  localparam int N  = 7;
  localparam int LC = 4;
  localparam logic [15:0] A_RAW = 16'h8064;
  localparam logic [15:0] B_RAW = 16'h7F9C;

  logic             clk_in = 1'b0;
  logic             rstn_in;
  logic [N*16-1:0]  fADC_in;
  logic [N-1:0]     fADC_sel_in;
  logic [N*32-1:0]  s_out;
  logic [N-1:0]     s_valid_out;
  logic [N-1:0]     locked_out;
  logic [N-1:0]     err_out;
  logic [N*8-1:0]   err_cnt_out;

  always #5 clk_in = ~clk_in;

  fast_adc_rx #(.N_ADC(N), .LOCK_CNT(LC), .OFFSET_BIN(1'b1)) dut (
    .clk_in      (clk_in),
    .rstn_in     (rstn_in),
    .fADC_in     (fADC_in),
    .fADC_sel_in (fADC_sel_in),
    .s_out       (s_out),
    .s_valid_out (s_valid_out),
    .locked_out  (locked_out),
    .err_out     (err_out),
    .err_cnt_out (err_cnt_out)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] drv_data[N];
  logic        drv_sel[N];
  bit          slip_pat[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  // Model: word currently held at the input register, plus lane behaviour.
  logic [15:0] r_data[N];
  logic        r_sel[N];
  logic        m_prev[N];
  bit          m_locked[N];
  int          m_streak[N];
  logic [15:0] m_a[N];
  logic [15:0] pair_a[N];
  logic [15:0] pair_b[N];
  bit          m_valid[N];
  bit          m_err[N];
  int          m_errs[N];

  logic [N*32-1:0] exp_s;
  logic [N-1:0]    exp_valid, exp_locked, exp_err;
  logic [N*8-1:0]  exp_cnt;

  function automatic void pack_expected();
    for (int k = 0; k < N; k++) begin
      exp_s[32*k +: 32] = {pair_b[k], pair_a[k]};
      exp_valid[k]      = m_valid[k];
      exp_locked[k]     = m_locked[k];
      exp_err[k]        = m_err[k];
      exp_cnt[8*k +: 8] = m_errs[k][7:0];
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      r_data[k] = '0; r_sel[k] = 1'b0; m_prev[k] = 1'b0;
      m_locked[k] = 0; m_streak[k] = 0; m_a[k] = '0;
      pair_a[k] = '0; pair_b[k] = '0;
      m_valid[k] = 0; m_err[k] = 0; m_errs[k] = 0;
    end
    pack_expected();
  endfunction

  // Consumes the word at the input register; results appear one edge later.
  function automatic void model_word(int k);
    logic [15:0] v;
    bit rep;
    v   = r_data[k] ^ 16'h8000;
    rep = (r_sel[k] == m_prev[k]);
    m_valid[k] = 0;
    m_err[k]   = 0;
    if (!m_locked[k]) begin
      m_streak[k] = rep ? 0 : m_streak[k] + 1;
      if (m_streak[k] >= LC && r_sel[k]) begin
        m_locked[k] = 1;
        m_streak[k] = 0;
      end
    end else if (rep) begin
      m_err[k] = 1; m_locked[k] = 0; m_streak[k] = 0;
      if (m_errs[k] < 255) m_errs[k]++;
    end else if (!r_sel[k]) begin
      m_a[k] = v;
    end else begin
      pair_a[k] = m_a[k]; pair_b[k] = v; m_valid[k] = 1;
    end
    m_prev[k] = r_sel[k];
  endfunction

  function automatic void set_word(int k, logic sel);
    drv_sel[k]  = sel;
    drv_data[k] = (k == 0) ? (sel ? B_RAW : A_RAW) : 16'($urandom);
  endfunction

  function automatic void alt_all();
    for (int k = 0; k < N; k++) set_word(k, ~drv_sel[k]);
  endfunction

  task automatic cycle();
    for (int k = 0; k < N; k++) begin
      fADC_in[16*k +: 16] = drv_data[k];
      fADC_sel_in[k]      = drv_sel[k];
    end
    @(posedge clk_in);
    if (rstn_in) begin
      for (int k = 0; k < N; k++) begin
        model_word(k);
        r_data[k] = drv_data[k];
        r_sel[k]  = drv_sel[k];
      end
    end
    pack_expected();
    #1;
  endtask

  task automatic test_reset();
    rstn_in = 1'b0;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      alt_all();
      cycle();
      vectors += 5;
      if (s_out !== '0) begin miscompares++; $display("[TB] FAIL reset_s_out got %h want 0", s_out); end
      if (s_valid_out !== '0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", s_valid_out); end
      if (locked_out !== '0) begin miscompares++; $display("[TB] FAIL reset_locked got %b want 0", locked_out); end
      if (err_out !== '0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", err_out); end
      if (err_cnt_out !== '0) begin miscompares++; $display("[TB] FAIL reset_err_cnt got %h want 0", err_cnt_out); end
    end
    @(negedge clk_in);
    rstn_in = 1'b1;
    for (int c = 0; c < LC; c++) begin
      alt_all();
      cycle();
      vectors += 2;
      if (locked_out !== '0) begin miscompares++; $display("[TB] FAIL early_lock got %b want 0", locked_out); end
      if (s_valid_out !== exp_valid) begin miscompares++; $display("[TB] FAIL post_reset_valid got %b want %b", s_valid_out, exp_valid); end
    end
  endtask

  task automatic test_clean_stream();
    for (int c = 0; c < 24; c++) begin
      alt_all();
      cycle();
      vectors += 4;
      if (s_out !== exp_s) begin miscompares++; $display("[TB] FAIL clean_s_out got %h want %h", s_out, exp_s); end
      if (s_valid_out !== exp_valid) begin miscompares++; $display("[TB] FAIL clean_valid got %b want %b", s_valid_out, exp_valid); end
      if (locked_out !== exp_locked) begin miscompares++; $display("[TB] FAIL clean_locked got %b want %b", locked_out, exp_locked); end
      if (err_out !== exp_err) begin miscompares++; $display("[TB] FAIL clean_err got %b want %b", err_out, exp_err); end
      if (s_valid_out[0]) begin
        vectors++;
        if (s_out[31:0] !== 32'hFF9C_0064) begin miscompares++; $display("[TB] FAIL lane0_pair got %h want ff9c0064", s_out[31:0]); end
      end
    end
    vectors++;
    if (locked_out !== '1) begin miscompares++; $display("[TB] FAIL clean_all_locked got %b want 1111111", locked_out); end
  endtask

  task automatic test_framing_slip();
    bit forced[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int pulses = 0;
    if (drv_sel[0] == 1'b0) begin alt_all(); cycle(); end
    for (int c = 0; c < 24; c++) begin
      alt_all();
      if (c < 4) set_word(0, forced[c]);
      cycle();
      if (err_out[0]) pulses++;
      vectors += 4;
      if (s_out !== exp_s) begin miscompares++; $display("[TB] FAIL slip_s_out got %h want %h", s_out, exp_s); end
      if (s_valid_out !== exp_valid) begin miscompares++; $display("[TB] FAIL slip_valid got %b want %b", s_valid_out, exp_valid); end
      if (locked_out !== exp_locked) begin miscompares++; $display("[TB] FAIL slip_locked got %b want %b", locked_out, exp_locked); end
      if (err_out !== exp_err) begin miscompares++; $display("[TB] FAIL slip_err got %b want %b", err_out, exp_err); end
      if (s_valid_out[0]) begin
        vectors++;
        if (s_out[31:0] !== 32'hFF9C_0064) begin miscompares++; $display("[TB] FAIL slip_pair got %h want ff9c0064", s_out[31:0]); end
      end
    end
    vectors += 3;
    if (pulses != 1) begin miscompares++; $display("[TB] FAIL slip_pulses got %0d want 1", pulses); end
    if (err_cnt_out[7:0] !== 8'd1) begin miscompares++; $display("[TB] FAIL slip_err_cnt got %0d want 1", err_cnt_out[7:0]); end
    if (locked_out[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL slip_relock got %b want 1", locked_out[0]); end
  endtask

  task automatic test_lane_independence();
    logic [N-1:0] others;
    logic [7:0]   start_cnt;
    others    = ~(7'b1 << 3);
    start_cnt = err_cnt_out[31:24];
    for (int c = 0; c < 42; c++) begin
      alt_all();
      set_word(3, slip_pat[c % 7]);
      cycle();
      vectors += 4;
      if ((err_out & others) !== '0) begin miscompares++; $display("[TB] FAIL indep_err got %b want 0 outside lane 3", err_out); end
      if ((locked_out & others) !== others) begin miscompares++; $display("[TB] FAIL indep_locked got %b want %b", locked_out & others, others); end
      if (s_valid_out !== exp_valid) begin miscompares++; $display("[TB] FAIL indep_valid got %b want %b", s_valid_out, exp_valid); end
      if (err_cnt_out !== exp_cnt) begin miscompares++; $display("[TB] FAIL indep_err_cnt got %h want %h", err_cnt_out, exp_cnt); end
    end
    vectors++;
    if (!(err_cnt_out[31:24] > start_cnt)) begin miscompares++; $display("[TB] FAIL indep_lane3_cnt got %0d want >%0d", err_cnt_out[31:24], start_cnt); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 7 * 310; c++) begin
      alt_all();
      set_word(5, slip_pat[c % 7]);
      cycle();
      vectors += 3;
      if (err_cnt_out !== exp_cnt) begin miscompares++; $display("[TB] FAIL sat_err_cnt got %h want %h", err_cnt_out, exp_cnt); end
      if (err_out !== exp_err) begin miscompares++; $display("[TB] FAIL sat_err got %b want %b", err_out, exp_err); end
      if (s_out !== exp_s) begin miscompares++; $display("[TB] FAIL sat_s_out got %h want %h", s_out, exp_s); end
    end
    vectors++;
    if (err_cnt_out[47:40] !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_final got %0d want 255", err_cnt_out[47:40]); end
  endtask

  task automatic test_reset_mid_pair();
    for (int c = 0; c < 12; c++) begin alt_all(); cycle(); end
    if (drv_sel[0] == 1'b0) begin alt_all(); cycle(); end
    vectors++;
    if (locked_out !== '1) begin miscompares++; $display("[TB] FAIL pre_reset_locked got %b want 1111111", locked_out); end
    alt_all();
    cycle();
    @(negedge clk_in);
    rstn_in = 1'b0;
    model_reset();
    #1;
    vectors += 4;
    if (s_out !== '0) begin miscompares++; $display("[TB] FAIL async_s_out got %h want 0", s_out); end
    if (s_valid_out !== '0) begin miscompares++; $display("[TB] FAIL async_valid got %b want 0", s_valid_out); end
    if (locked_out !== '0) begin miscompares++; $display("[TB] FAIL async_locked got %b want 0", locked_out); end
    if (err_cnt_out !== '0) begin miscompares++; $display("[TB] FAIL async_err_cnt got %h want 0", err_cnt_out); end
    alt_all();
    cycle();
    vectors += 2;
    if (s_valid_out !== '0) begin miscompares++; $display("[TB] FAIL midpair_valid got %b want 0", s_valid_out); end
    if (s_out !== '0) begin miscompares++; $display("[TB] FAIL midpair_s_out got %h want 0", s_out); end
    @(negedge clk_in);
    rstn_in = 1'b1;
    for (int c = 0; c < 16; c++) begin
      alt_all();
      cycle();
      vectors += 3;
      if (locked_out !== exp_locked) begin miscompares++; $display("[TB] FAIL rehunt_locked got %b want %b", locked_out, exp_locked); end
      if (s_valid_out !== exp_valid) begin miscompares++; $display("[TB] FAIL rehunt_valid got %b want %b", s_valid_out, exp_valid); end
      if (s_out !== exp_s) begin miscompares++; $display("[TB] FAIL rehunt_s_out got %h want %h", s_out, exp_s); end
    end
  endtask

  initial begin
    fADC_in     = '0;
    fADC_sel_in = '0;
    for (int k = 0; k < N; k++) begin
      drv_sel[k]  = 1'b0;
      drv_data[k] = '0;
    end
    test_reset();
    test_clean_stream();
    test_framing_slip();
    test_lane_independence();
    test_saturation();
    test_reset_mid_pair();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
